// File: rtl/calc_macro_arbiter_if.sv
// Request and queue-write bus between the macro requesters, calc's instruction ring and calc_macro_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding top level.
interface calc_macro_arbiter_if #(
  parameter int QLOG2       = 2,
  parameter int MACRO_WORDS = 4,
  parameter int HEIGHT_W    = 9
);
  logic [1:0]               req_valid;
  logic [32*MACRO_WORDS-1:0] req_macro0;
  logic [32*MACRO_WORDS-1:0] req_macro1;
  logic [HEIGHT_W-1:0]      req_min_height0;
  logic [HEIGHT_W-1:0]      req_min_height1;
  logic [1:0]               req_ack;
  logic [1:0]               req_reject;
  logic [HEIGHT_W-1:0]      stack_height;
  logic [QLOG2-1:0]         q_read_head;
  logic [QLOG2-1:0]         q_write_head;
  logic                     q_wr_en;
  logic [31:0]              q_wr_data;
  logic                     busy;
  logic                     grant_id;
  logic [15:0]              stall_cycles;
  logic [15:0]              macros_issued;

  modport slave (
    input  req_valid, req_macro0, req_macro1, req_min_height0, req_min_height1,
    input  stack_height, q_read_head,
    output req_ack, req_reject, q_write_head, q_wr_en, q_wr_data,
    output busy, grant_id, stall_cycles, macros_issued
  );

  modport master (
    output req_valid, req_macro0, req_macro1, req_min_height0, req_min_height1,
    output stack_height, q_read_head,
    input  req_ack, req_reject, q_write_head, q_wr_en, q_wr_data,
    input  busy, grant_id, stall_cycles, macros_issued
  );
endinterface

// File: rtl/calc_macro_arbiter.sv
// Round-robin arbiter streaming 2 requesters' instruction macros atomically into calc's ring queue.
// Define CALC_ARB_STATS_EN to build the stall_cycles / macros_issued counters; otherwise both read 0.
module calc_macro_arbiter #(
  parameter int QLOG2       = 2,
  parameter int MACRO_WORDS = 4,
  parameter int HEIGHT_W    = 9
) (
  input logic                 clk,
  input logic                 rst,
  calc_macro_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MACRO_WORDS + 1);
  localparam int BUF_W = 32 * MACRO_WORDS;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic              rr;
  logic [BUF_W-1:0]  word_buf;
  logic [CNT_W-1:0]  word_cnt;
  logic [QLOG2-1:0]  write_head;
  logic [QLOG2-1:0]  head_next;
  logic [1:0]        ack;
  logic [1:0]        reject;
  logic              grant_reg;
  logic              q_empty;
  logic              q_full;
  logic              issue_done;
  logic              winner;
  logic              height_ok;
  logic              arbitrate;

  assign head_next  = write_head + QLOG2'(1);
  assign q_empty    = (write_head == bus.q_read_head);
  assign q_full     = (head_next == bus.q_read_head);
  assign issue_done = (word_buf[31:0] == 32'd0) || (word_cnt == CNT_W'(MACRO_WORDS));
  assign arbitrate  = (state == IDLE) && q_empty && (|bus.req_valid);

  // On contention rr names the requester that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (bus.req_valid == 2'b11)
      winner = rr;
    else if (bus.req_valid[1])
      winner = 1'b1;
  end

  assign height_ok = winner ? (bus.stack_height >= bus.req_min_height1)
                            : (bus.stack_height >= bus.req_min_height0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      word_buf   <= '0;
      word_cnt   <= '0;
      write_head <= '0;
      ack        <= '0;
      reject     <= '0;
      grant_reg  <= 1'b0;
    end else begin
      ack    <= '0;
      reject <= '0;
      case (state)
        IDLE: begin
          if (arbitrate) begin
            rr <= ~winner;
            if (height_ok) begin
              word_buf    <= winner ? bus.req_macro1 : bus.req_macro0;
              word_cnt    <= '0;
              ack[winner] <= 1'b1;
              grant_reg   <= winner;
              state       <= ISSUE;
            end else begin
              reject[winner] <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue_done) begin
            state <= IDLE;
          end else if (!q_full) begin
            write_head <= head_next;
            word_buf   <= word_buf >> 32;
            word_cnt   <= word_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q_wr_en      = (state == ISSUE) && !issue_done && !q_full && !rst;
  assign bus.q_wr_data    = word_buf[31:0];
  assign bus.q_write_head = write_head;
  assign bus.req_ack      = ack;
  assign bus.req_reject   = reject;
  assign bus.busy         = (state == ISSUE);
  assign bus.grant_id     = grant_reg;

`ifdef CALC_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] issued_cnt;

  // Both counters saturate rather than wrap so long soak runs stay meaningful.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      issued_cnt <= '0;
    end else begin
      if ((state == ISSUE) && !issue_done && q_full && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (arbitrate && height_ok && (issued_cnt != 16'hFFFF))
        issued_cnt <= issued_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles  = stall_cnt;
  assign bus.macros_issued = issued_cnt;
`else
  assign bus.stall_cycles  = 16'd0;
  assign bus.macros_issued = 16'd0;
`endif
endmodule

// File: tb/tb_calc_macro_arbiter.sv
// Directed bench for calc_macro_arbiter: grant order, reject path, full-queue stall and mid-issue reset.
module tb_calc_macro_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef CALC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  calc_macro_arbiter_if #(.QLOG2(2), .MACRO_WORDS(4), .HEIGHT_W(9)) bus ();

  calc_macro_arbiter #(.QLOG2(2), .MACRO_WORDS(4), .HEIGHT_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    bus.req_valid       = 2'b00;
    bus.req_macro0      = '0;
    bus.req_macro1      = '0;
    bus.req_min_height0 = '0;
    bus.req_min_height1 = '0;
    bus.stack_height    = '0;
    bus.q_read_head     = '0;

    // Reset values
    tick();
    tick();
    check_output("rst_head",   32'(bus.q_write_head), 32'd0);
    check_output("rst_ack",    32'(bus.req_ack), 32'd0);
    check_output("rst_rej",    32'(bus.req_reject), 32'd0);
    check_output("rst_busy",   32'(bus.busy), 32'd0);
    check_output("rst_gid",    32'(bus.grant_id), 32'd0);
    check_output("rst_wren",   32'(bus.q_wr_en), 32'd0);
    check_output("rst_wdata",  bus.q_wr_data, 32'd0);
    check_output("rst_stall",  32'(bus.stall_cycles), 32'd0);
    check_output("rst_issued", 32'(bus.macros_issued), 32'd0);
    rst = 1'b0;

    // Three-word macro from requester 0 into an empty queue
    bus.stack_height    = 9'd5;
    bus.req_macro0      = {32'h0, 32'h9000_0000, 32'hC000_0000, 32'h8000_0000};
    bus.req_min_height0 = 9'd0;
    bus.req_valid       = 2'b01;
    tick();
    check_output("t1_ack",   32'(bus.req_ack), 32'd1);
    check_output("t1_busy",  32'(bus.busy), 32'd1);
    check_output("t1_gid",   32'(bus.grant_id), 32'd0);
    check_output("t1_wren0", 32'(bus.q_wr_en), 32'd1);
    check_output("t1_data0", bus.q_wr_data, 32'h8000_0000);
    check_output("t1_head0", 32'(bus.q_write_head), 32'd0);
    bus.req_valid = 2'b00;
    tick();
    check_output("t1_ackoff", 32'(bus.req_ack), 32'd0);
    check_output("t1_head1",  32'(bus.q_write_head), 32'd1);
    check_output("t1_data1",  bus.q_wr_data, 32'hC000_0000);
    tick();
    check_output("t1_head2", 32'(bus.q_write_head), 32'd2);
    check_output("t1_data2", bus.q_wr_data, 32'h9000_0000);
    check_output("t1_wren2", 32'(bus.q_wr_en), 32'd1);
    tick();
    check_output("t1_head3", 32'(bus.q_write_head), 32'd3);
    check_output("t1_wren3", 32'(bus.q_wr_en), 32'd0);
    check_output("t1_busy3", 32'(bus.busy), 32'd1);
    tick();
    check_output("t1_idle", 32'(bus.busy), 32'd0);
    bus.q_read_head = 2'd3;

    // Both valid after requester 0 won: requester 1 goes first
    bus.req_macro0      = {96'h0, 32'h0000_0011};
    bus.req_macro1      = {64'h0, 32'h0000_0022, 32'h0000_0021};
    bus.req_min_height1 = 9'd0;
    bus.req_valid       = 2'b11;
    tick();
    check_output("t2_ack1",  32'(bus.req_ack), 32'd2);
    check_output("t2_gid1",  32'(bus.grant_id), 32'd1);
    check_output("t2_data0", bus.q_wr_data, 32'h0000_0021);
    bus.req_valid = 2'b01;
    tick();
    check_output("t2_wrap",  32'(bus.q_write_head), 32'd0);
    check_output("t2_data1", bus.q_wr_data, 32'h0000_0022);
    check_output("t2_noack", 32'(bus.req_ack), 32'd0);
    tick();
    check_output("t2_head1", 32'(bus.q_write_head), 32'd1);
    check_output("t2_wren",  32'(bus.q_wr_en), 32'd0);
    tick();
    check_output("t2_idle", 32'(bus.busy), 32'd0);
    tick();
    check_output("t2_wait_ack",  32'(bus.req_ack), 32'd0);
    check_output("t2_wait_busy", 32'(bus.busy), 32'd0);
    bus.q_read_head = 2'd1;
    tick();
    check_output("t2_ack0", 32'(bus.req_ack), 32'd1);
    check_output("t2_gid0", 32'(bus.grant_id), 32'd0);
    check_output("t2_d0",   bus.q_wr_data, 32'h0000_0011);
    bus.req_valid = 2'b00;
    tick();
    check_output("t2_head2", 32'(bus.q_write_head), 32'd2);
    tick();
    tick();
    check_output("t2_idle2", 32'(bus.busy), 32'd0);
    bus.q_read_head = 2'd2;

    // Reject on shallow stack, pointer flips, then both requests served
    bus.stack_height    = 9'd1;
    bus.req_min_height1 = 9'd2;
    bus.req_macro1      = {96'h0, 32'h0000_0033};
    bus.req_valid       = 2'b10;
    tick();
    check_output("t3_rej",   32'(bus.req_reject), 32'd2);
    check_output("t3_noack", 32'(bus.req_ack), 32'd0);
    check_output("t3_wren",  32'(bus.q_wr_en), 32'd0);
    check_output("t3_busy",  32'(bus.busy), 32'd0);
    bus.stack_height = 9'd2;
    bus.req_macro0   = {96'h0, 32'h0000_0044};
    bus.req_valid    = 2'b11;
    tick();
    check_output("t3_rr_ack", 32'(bus.req_ack), 32'd1);
    check_output("t3_rejoff", 32'(bus.req_reject), 32'd0);
    check_output("t3_d44",    bus.q_wr_data, 32'h0000_0044);
    bus.req_valid = 2'b10;
    tick();
    check_output("t3_head3", 32'(bus.q_write_head), 32'd3);
    tick();
    check_output("t3_idle", 32'(bus.busy), 32'd0);
    bus.q_read_head = 2'd3;
    tick();
    check_output("t3_ack1", 32'(bus.req_ack), 32'd2);
    check_output("t3_gid1", 32'(bus.grant_id), 32'd1);
    check_output("t3_d33",  bus.q_wr_data, 32'h0000_0033);
    bus.req_valid = 2'b00;
    tick();
    check_output("t3_wrap", 32'(bus.q_write_head), 32'd0);
    tick();
    check_output("t3_idle2", 32'(bus.busy), 32'd0);
    bus.q_read_head = 2'd0;

    // Four-word macro against a frozen reader: stall at head 3, then wrap
    bus.req_macro0 = {32'h0000_00A4, 32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1};
    bus.req_valid  = 2'b01;
    tick();
    check_output("t4_ack", 32'(bus.req_ack), 32'd1);
    bus.req_valid = 2'b00;
    tick();
    check_output("t4_h1", 32'(bus.q_write_head), 32'd1);
    tick();
    check_output("t4_h2", 32'(bus.q_write_head), 32'd2);
    tick();
    check_output("t4_h3",     32'(bus.q_write_head), 32'd3);
    check_output("t4_stall0", 32'(bus.q_wr_en), 32'd0);
    tick();
    check_output("t4_stallh",  32'(bus.q_write_head), 32'd3);
    check_output("t4_stall1",  32'(bus.q_wr_en), 32'd0);
    check_output("t4_stbusy",  32'(bus.busy), 32'd1);
    tick();
    check_output("t4_stall2", 32'(bus.q_wr_en), 32'd0);
    bus.q_read_head = 2'd2;
    #1;
    check_output("t4_rel_wren", 32'(bus.q_wr_en), 32'd1);
    check_output("t4_rel_data", bus.q_wr_data, 32'h0000_00A4);
    tick();
    check_output("t4_wrap",   32'(bus.q_write_head), 32'd0);
    check_output("t4_done",   32'(bus.q_wr_en), 32'd0);
    check_output("t4_stalls", 32'(bus.stall_cycles), STATS ? 32'd2 : 32'd0);
    check_output("t4_issued", 32'(bus.macros_issued), STATS ? 32'd6 : 32'd0);
    tick();
    check_output("t4_idle", 32'(bus.busy), 32'd0);
    bus.q_read_head = 2'd0;

    // Reset after two of four words abandons the rest
    bus.req_macro1      = {32'h0000_00B4, 32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1};
    bus.req_min_height1 = 9'd0;
    bus.req_valid       = 2'b10;
    tick();
    check_output("t5_ack", 32'(bus.req_ack), 32'd2);
    bus.req_valid = 2'b00;
    tick();
    tick();
    check_output("t5_h2", 32'(bus.q_write_head), 32'd2);
    rst = 1'b1;
    tick();
    check_output("t5_rst_head",  32'(bus.q_write_head), 32'd0);
    check_output("t5_rst_busy",  32'(bus.busy), 32'd0);
    check_output("t5_rst_wren",  32'(bus.q_wr_en), 32'd0);
    check_output("t5_rst_stall", 32'(bus.stall_cycles), 32'd0);
    rst = 1'b0;
    tick();
    check_output("t5_quiet", 32'(bus.q_wr_en), 32'd0);
    bus.req_macro0 = {96'h0, 32'h0000_00C1};
    bus.req_valid  = 2'b01;
    tick();
    check_output("t5_ack0", 32'(bus.req_ack), 32'd1);
    check_output("t5_gid0", 32'(bus.grant_id), 32'd0);
    check_output("t5_dc1",  bus.q_wr_data, 32'h0000_00C1);
    bus.req_valid = 2'b00;
    tick();
    check_output("t5_h1",     32'(bus.q_write_head), 32'd1);
    check_output("t5_issued", 32'(bus.macros_issued), STATS ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
